chunk_sum_alu: RTL

Parametrised multi-cycle adder/subtractor for the ALU operations group. It is the sequential successor of the fixed 32-bit ripple sum unit. Operands are added `CHUNK` bits per clock, with a registered carry between chunks. This bounds the carry path to `CHUNK` bits at the cost of `WIDTH/CHUNK` cycles of latency. A start/busy/done handshake lets the ALU control logic sequence it.

---
 rtl/chunk_sum_alu.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/chunk_sum_alu.sv
// -----------------------------------------------------------------------------
// chunk_sum_alu
//
// Multi-cycle adder/subtractor. It adds CHUNK bits per clock and keeps a
// registered carry between chunks, so the carry path is never longer than
// CHUNK bits. An operation takes N = WIDTH/CHUNK RUN cycles followed by one
// DONE cycle. A start/busy/done handshake sequences it.
//
// State | Meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start; result and flags hold the last operation
// RUN   | adding chunk idx_q; busy = 1
// DONE  | result and flags valid; done = 1; start here chains immediately
//
// Parameters
//   WIDTH    operand/result width; must be a multiple of CHUNK
//   CHUNK    bits processed per clock (1 <= CHUNK <= WIDTH)
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   start     launch an operation; only sampled in IDLE or DONE
//   sub       0 = A + B + Cin, 1 = A - B (sampled with start)
//   Cin       carry-in for add; ignored when sub = 1
//   A, B      operands (sampled with start)
//   busy      high while chunks are being added
//   done      single-cycle pulse; result and flags valid
//   result    sum/difference, held until the next accepted start
//   Cout      carry out of the MSB (for subtract, 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//   zero      result == 0
//
// Build option
//   CHUNK_SUM_SAT_EN  when defined, a signed overflow saturates result to the
//                     largest positive or most negative value according to
//                     the sign of A. zero follows the saturated value, while
//                     overflow and Cout still report the raw condition.
//                     When undefined, result is the wrapped value and no
//                     saturation logic is built.
// -----------------------------------------------------------------------------
module chunk_sum_alu #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // B already inverted for subtract
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             msb_carry_in;
    logic             raw_ovf;
    logic [WIDTH-1:0] raw_full;
    logic [WIDTH-1:0] final_full;

    always_comb begin
        chunk_a    = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b    = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (idx_q == LAST_IDX);

        // Sum bit = a ^ b ^ carry-in, so the carry into the chunk MSB can be
        // recovered from the sum bit without a separate (CHUNK-1)-bit adder.
        // This also covers CHUNK = 1, where it equals carry_q.
        msb_carry_in = chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
        raw_ovf      = msb_carry_in ^ chunk_sum[CHUNK];

        // Result was cleared at start and chunks are filled LSB first, so on
        // the last chunk this is the complete wrapped value.
        raw_full = result;
        raw_full[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];

        final_full = raw_full;
`ifdef CHUNK_SUM_SAT_EN
        // Signed overflow can only happen when the true result has A's sign,
        // so A's sign selects the saturation rail for both add and subtract.
        if (raw_ovf) begin
            final_full = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result   <= '0;
            Cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{sub}};
                        carry_q <= sub ? 1'b1 : Cin;
                        idx_q   <= '0;
                        result  <= '0;
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (last_chunk) begin
                        result   <= final_full;
                        Cout     <= chunk_sum[CHUNK];
                        overflow <= raw_ovf;
                        zero     <= (final_full == '0);
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        result  <= raw_full;
                        carry_q <= chunk_sum[CHUNK];
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
